// File: rtl/ucode_data_reader.sv
// ucode_data_reader: expands one data-read uCode word into a 1-6 beat SRAM read burst
// and realigns returned data with its beat metadata. Optional macro: UCODE_MODE_CHECK_EN.
module ucode_data_reader #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [23:0]       Data_Read_uCode,
    output logic              uCode_Ready,
    input  logic              Stall,
    output logic              Rd_En,
    output logic [ADDR_W-1:0] Rd_Addr,
    input  logic [DATA_W-1:0] Rd_Data,
    output logic [DATA_W-1:0] Data_Out,
    output logic              Data_Out_Valid,
    output logic [2:0]        Beat_Idx,
    output logic              Last_Beat,
    output logic [8:0]        Mode_Out,
    output logic              Mode_Err
);

    typedef enum logic {IDLE, ISSUE} state_t;

    logic [8:0] width_f;
    logic [4:0] depth_f;
    logic [8:0] mode_f;
    logic       enable_f;

    assign width_f  = Data_Read_uCode[23:15];
    assign depth_f  = Data_Read_uCode[14:10];
    assign mode_f   = Data_Read_uCode[9:1];
    assign enable_f = Data_Read_uCode[0];

    // Highest set mode bit wins; unlisted modes decode to length 0 and are dropped.
    logic [8:0] sel_mode;
    logic [2:0] sel_len;

    always_comb begin
        sel_mode = '0;
        for (int i = 0; i < 9; i++) begin
            if (mode_f[i]) begin
                sel_mode    = '0;
                sel_mode[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_len = 3'd0;
        case (sel_mode)
            9'b001000000: sel_len = 3'd6;
            9'b000100000: sel_len = 3'd2;
            9'b000010000: sel_len = 3'd4;
            9'b000001000: sel_len = 3'd4;
            9'b000000100: sel_len = 3'd1;
            9'b000000010: sel_len = 3'd5;
            9'b000000001: sel_len = 3'd5;
            default:      sel_len = 3'd0;
        endcase
    end

    logic word_ok;
`ifdef UCODE_MODE_CHECK_EN
    logic multi_hot;
    assign multi_hot = ($countones(mode_f) > 1);
    assign word_ok   = (sel_len != 3'd0) && !multi_hot;
`else
    assign word_ok   = (sel_len != 3'd0);
`endif

    state_t            state_reg;
    logic [2:0]        beat_reg;
    logic [2:0]        len_reg;
    logic [8:0]        mode_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] base;
    logic              last_beat;
    logic              accept;
    logic              start;
    logic              issue;

    assign base      = ADDR_W'({depth_f, width_f});
    assign last_beat = (beat_reg == len_reg - 3'd1);

    // Ready opens on the final beat so the next burst follows without a bubble.
    assign uCode_Ready = !Reset && ((state_reg == IDLE) ||
                                    ((state_reg == ISSUE) && last_beat && !Stall));
    assign accept      = enable_f && uCode_Ready && !Stall;
    assign start       = accept && word_ok;
    assign issue       = !Reset && (state_reg == ISSUE) && !Stall;

    assign Rd_En   = issue;
    assign Rd_Addr = addr_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
            len_reg   <= '0;
            mode_reg  <= '0;
            addr_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= ISSUE;
                        beat_reg  <= '0;
                        len_reg   <= sel_len;
                        mode_reg  <= sel_mode;
                        addr_reg  <= base;
                    end
                end
                ISSUE: begin
                    if (!Stall) begin
                        if (last_beat) begin
                            if (start) begin
                                beat_reg <= '0;
                                len_reg  <= sel_len;
                                mode_reg <= sel_mode;
                                addr_reg <= base;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            beat_reg <= beat_reg + 3'd1;
                            addr_reg <= addr_reg + ADDR_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Metadata travels alongside the SRAM access so it lines up with Rd_Data.
    logic       pipe_valid [RD_LATENCY];
    logic [2:0] pipe_beat  [RD_LATENCY];
    logic       pipe_last  [RD_LATENCY];
    logic [8:0] pipe_mode  [RD_LATENCY];

    generate
        for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_meta
            if (gi == 0) begin : g_head
                always_ff @(posedge Clk) begin
                    if (Reset) begin
                        pipe_valid[0] <= 1'b0;
                        pipe_beat[0]  <= '0;
                        pipe_last[0]  <= 1'b0;
                        pipe_mode[0]  <= '0;
                    end else begin
                        pipe_valid[0] <= issue;
                        pipe_beat[0]  <= beat_reg;
                        pipe_last[0]  <= last_beat;
                        pipe_mode[0]  <= mode_reg;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge Clk) begin
                    if (Reset) begin
                        pipe_valid[gi] <= 1'b0;
                        pipe_beat[gi]  <= '0;
                        pipe_last[gi]  <= 1'b0;
                        pipe_mode[gi]  <= '0;
                    end else begin
                        pipe_valid[gi] <= pipe_valid[gi-1];
                        pipe_beat[gi]  <= pipe_beat[gi-1];
                        pipe_last[gi]  <= pipe_last[gi-1];
                        pipe_mode[gi]  <= pipe_mode[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Data_Out       <= '0;
            Data_Out_Valid <= 1'b0;
            Beat_Idx       <= '0;
            Last_Beat      <= 1'b0;
            Mode_Out       <= '0;
        end else begin
            Data_Out_Valid <= pipe_valid[RD_LATENCY-1];
            if (pipe_valid[RD_LATENCY-1]) begin
                Data_Out  <= Rd_Data;
                Beat_Idx  <= pipe_beat[RD_LATENCY-1];
                Last_Beat <= pipe_last[RD_LATENCY-1];
                Mode_Out  <= pipe_mode[RD_LATENCY-1];
            end
        end
    end

`ifdef UCODE_MODE_CHECK_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Mode_Err <= 1'b0;
        end else if (accept && multi_hot) begin
            Mode_Err <= 1'b1;
        end
    end
`else
    assign Mode_Err = 1'b0;
`endif

endmodule

// File: tb/tb_ucode_data_reader.sv
// Directed bench for ucode_data_reader: expected reads and output beats are queued
// as each word is driven and compared cycle by cycle against the DUT.
module tb_ucode_data_reader;

    localparam int LAT = 1;

    localparam logic [8:0] M_C1  = 9'b001000000;
    localparam logic [8:0] M_MP  = 9'b000100000;
    localparam logic [8:0] M_C2  = 9'b000010000;
    localparam logic [8:0] M_C3  = 9'b000001000;
    localparam logic [8:0] M_GMP = 9'b000000100;
    localparam logic [8:0] M_FC1 = 9'b000000010;
    localparam logic [8:0] M_FC2 = 9'b000000001;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic [23:0] Data_Read_uCode = '0;
    logic        uCode_Ready;
    logic        Rd_En;
    logic [13:0] Rd_Addr;
    logic [7:0]  Rd_Data;
    logic [7:0]  Data_Out;
    logic        Data_Out_Valid;
    logic [2:0]  Beat_Idx;
    logic        Last_Beat;
    logic [8:0]  Mode_Out;
    logic        Mode_Err;

    always #5 Clk = ~Clk;

    ucode_data_reader #(
        .ADDR_W(14), .DATA_W(8), .RD_LATENCY(LAT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Data_Read_uCode(Data_Read_uCode),
        .uCode_Ready(uCode_Ready), .Stall(Stall), .Rd_En(Rd_En), .Rd_Addr(Rd_Addr),
        .Rd_Data(Rd_Data), .Data_Out(Data_Out), .Data_Out_Valid(Data_Out_Valid),
        .Beat_Idx(Beat_Idx), .Last_Beat(Last_Beat), .Mode_Out(Mode_Out), .Mode_Err(Mode_Err)
    );

    function automatic logic [7:0] sram_word(input logic [13:0] a);
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A;
    endfunction

    // SRAM model: data for the address presented with Rd_En appears LAT cycles later.
    logic [7:0] mem_pipe [LAT];
    always @(posedge Clk) begin
        mem_pipe[0] <= sram_word(Rd_Addr);
        for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign Rd_Data = mem_pipe[LAT-1];

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;
    bit skip_rd = 1'b0;

    typedef struct {
        int          due;
        logic [13:0] addr;
    } rd_t;

    typedef struct {
        int         due;
        logic [7:0] data;
        logic [2:0] beat;
        logic       last;
        logic [8:0] mode;
    } out_t;

    rd_t  rd_q[$];
    out_t out_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] mk(input int w, input int d, input logic [8:0] m, input logic en);
        return {9'(w), 5'(d), m, en};
    endfunction

    task automatic push_rd(input logic [13:0] a, input int beat, input logic last,
                           input logic [8:0] m, input int due, input bit keep);
        rd_t  r;
        out_t o;
        r.due  = due;
        r.addr = a;
        rd_q.push_back(r);
        if (keep) begin
            o.due  = due + LAT + 1;
            o.data = sram_word(a);
            o.beat = 3'(beat);
            o.last = last;
            o.mode = m;
            out_q.push_back(o);
        end
    endtask

    task automatic push_burst(input logic [13:0] base, input int n, input logic [8:0] m, input int first);
        for (int k = 0; k < n; k++) push_rd(base + 14'(k), k, (k == n - 1), m, first + k, 1'b1);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((rd_q.size() != 0 || out_q.size() != 0) && n < 60) begin
            step();
            n++;
        end
        chk("drain_pending", 32'(rd_q.size() + out_q.size()), 32'd0);
        rd_q.delete();
        out_q.delete();
        step();
    endtask

    // Per-cycle scoreboard: every cycle is either an expected read/beat or must be idle.
    always @(negedge Clk) begin
        rd_t  r;
        out_t o;
        if (mon_on) begin
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                r = rd_q.pop_front();
                chk("rd_en", 32'(Rd_En), 32'd1);
                chk("rd_addr", 32'(Rd_Addr), 32'(r.addr));
            end else if (!skip_rd) begin
                chk("no_read", 32'(Rd_En), 32'd0);
            end
            if (out_q.size() > 0 && out_q[0].due == cyc) begin
                o = out_q.pop_front();
                chk("dout_valid", 32'(Data_Out_Valid), 32'd1);
                chk("dout_data", 32'(Data_Out), 32'(o.data));
                chk("beat_idx", 32'(Beat_Idx), 32'(o.beat));
                chk("last_beat", 32'(Last_Beat), 32'(o.last));
                chk("mode_out", 32'(Mode_Out), 32'(o.mode));
            end else begin
                chk("no_valid", 32'(Data_Out_Valid), 32'd0);
            end
        end
    end

    initial begin
        int c;
        Reset = 1'b1;
        Stall = 1'b0;
        Data_Read_uCode = '0;
        step(); step(); step();
        @(negedge Clk);
        chk("rst_rd_en", 32'(Rd_En), 32'd0);
        chk("rst_ready", 32'(uCode_Ready), 32'd0);
        chk("rst_valid", 32'(Data_Out_Valid), 32'd0);
        chk("rst_addr", 32'(Rd_Addr), 32'd0);
        chk("rst_dout", 32'(Data_Out), 32'd0);
        chk("rst_mode_err", 32'(Mode_Err), 32'd0);
        step();
        Reset = 1'b0;
        mon_on = 1'b1;
        @(negedge Clk);
        chk("ready_idle", 32'(uCode_Ready), 32'd1);

        // CONV1D_1st, 6 beats from address 10
        step(); c = cyc;
        Data_Read_uCode = mk(10, 0, M_C1, 1'b1);
        push_burst(14'd10, 6, M_C1, c + 1);
        step(); Data_Read_uCode = '0;
        drain();

        // MaxPool then FC_2nd held on the input until the last beat: no bubble
        step(); c = cyc;
        Data_Read_uCode = mk(20, 3, M_MP, 1'b1);
        push_burst(14'd1556, 2, M_MP, c + 1);
        step(); Data_Read_uCode = mk(0, 0, M_FC2, 1'b1);
        @(negedge Clk);
        chk("ready_mid_burst", 32'(uCode_Ready), 32'd0);
        step();
        push_burst(14'd0, 5, M_FC2, c + 3);
        @(negedge Clk);
        chk("ready_last_beat", 32'(uCode_Ready), 32'd1);
        step(); Data_Read_uCode = '0;
        drain();

        // CONV1D_2nd at the top of the address space wraps to 0
        step(); c = cyc;
        Data_Read_uCode = mk(510, 31, M_C2, 1'b1);
        push_burst(14'd16382, 4, M_C2, c + 1);
        step(); Data_Read_uCode = '0;
        drain();

        // CONV1D_3rd stalled for 3 cycles after beat 1
        step(); c = cyc;
        Data_Read_uCode = mk(100, 2, M_C3, 1'b1);
        push_rd(14'd1124, 0, 1'b0, M_C3, c + 1, 1'b1);
        push_rd(14'd1125, 1, 1'b0, M_C3, c + 2, 1'b1);
        push_rd(14'd1126, 2, 1'b0, M_C3, c + 6, 1'b1);
        push_rd(14'd1127, 3, 1'b1, M_C3, c + 7, 1'b1);
        step(); Data_Read_uCode = '0;
        step();
        for (int s = 0; s < 3; s++) begin
            step(); Stall = 1'b1;
            @(negedge Clk);
            chk("stall_ready", 32'(uCode_Ready), 32'd0);
            chk("stall_addr_hold", 32'(Rd_Addr), 32'd1126);
        end
        step(); Stall = 1'b0;
        drain();

        // Word presented while stalled in IDLE is taken only once the stall lifts
        step(); c = cyc;
        Stall = 1'b1;
        Data_Read_uCode = mk(1, 0, M_GMP, 1'b1);
        step(); c = cyc;
        Stall = 1'b0;
        push_burst(14'd1, 1, M_GMP, c + 1);
        step(); Data_Read_uCode = '0;
        drain();

        // Enable=0 and all-zero mode words produce no reads
        step(); Data_Read_uCode = mk(40, 1, M_C2, 1'b0);
        step(); Data_Read_uCode = mk(40, 1, 9'd0, 1'b1);
        step(); Data_Read_uCode = '0;
        step();
        @(negedge Clk);
        chk("ready_after_drop", 32'(uCode_Ready), 32'd1);

        // FC_1st aborted by reset on beat 3; beat 2 is still in flight and must vanish
        step(); c = cyc;
        Data_Read_uCode = mk(5, 1, M_FC1, 1'b1);
        push_rd(14'd517, 0, 1'b0, M_FC1, c + 1, 1'b1);
        push_rd(14'd518, 1, 1'b0, M_FC1, c + 2, 1'b1);
        push_rd(14'd519, 2, 1'b0, M_FC1, c + 3, 1'b0);
        step(); Data_Read_uCode = '0;
        step();
        step();
        step(); Reset = 1'b1; skip_rd = 1'b1;
        step(); Reset = 1'b0; skip_rd = 1'b0;
        @(negedge Clk);
        chk("abort_rd_en", 32'(Rd_En), 32'd0);
        chk("abort_valid", 32'(Data_Out_Valid), 32'd0);
        chk("abort_addr", 32'(Rd_Addr), 32'd0);
        chk("abort_dout", 32'(Data_Out), 32'd0);
        chk("abort_beat", 32'(Beat_Idx), 32'd0);
        chk("abort_last", 32'(Last_Beat), 32'd0);
        chk("abort_mode", 32'(Mode_Out), 32'd0);
        step(); c = cyc;
        Data_Read_uCode = mk(7, 0, M_GMP, 1'b1);
        push_burst(14'd7, 1, M_GMP, c + 1);
        step(); Data_Read_uCode = '0;
        drain();

        // Multi-bit mode word
        step(); c = cyc;
        Data_Read_uCode = mk(33, 4, 9'b000110000, 1'b1);
`ifdef UCODE_MODE_CHECK_EN
        step(); Data_Read_uCode = '0;
        @(negedge Clk);
        chk("mode_err_rise", 32'(Mode_Err), 32'd1);
        step(); step();
        @(negedge Clk);
        chk("mode_err_sticky", 32'(Mode_Err), 32'd1);
        step(); Reset = 1'b1;
        step(); Reset = 1'b0;
        @(negedge Clk);
        chk("mode_err_cleared", 32'(Mode_Err), 32'd0);
        step();
`else
        push_burst(14'd2081, 2, M_MP, c + 1);
        step(); Data_Read_uCode = '0;
        drain();
        chk("mode_err_tied", 32'(Mode_Err), 32'd0);
`endif

        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

endmodule
